// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch
// Purpose  : Architectural PC register and instruction-fetch stage. Fetches
//            over a req/ack memory handshake and hands the instruction to
//            decode over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] nextpc,
    output logic [31:0] outputpc,
    output logic [31:0] pc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instret
);

    localparam logic [1:0] c_BOOT  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_VALID = 2'd2;
    localparam logic [1:0] c_DRAIN = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_addr;
    logic [31:0] r_addr_hold;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic [31:0] r_instret;
    logic        w_fetching;

    assign w_fetching  = (r_state == c_FETCH) || (r_state == c_DRAIN);
    assign imem_req    = w_fetching;
    // Outside a request the bus keeps showing the last address it carried.
    assign imem_addr   = w_fetching ? r_fetch_addr : r_addr_hold;
    assign outputpc    = r_pc + 32'd1;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign instret     = r_instret;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= c_BOOT;
            r_pc          <= RESET_PC;
            r_fetch_addr  <= RESET_PC;
            r_addr_hold   <= RESET_PC;
            r_instr       <= 32'd0;
            r_instr_valid <= 1'b0;
            r_instret     <= 32'd0;
        end else begin
            if (w_fetching) begin
                r_addr_hold <= r_fetch_addr;
            end
            case (r_state)
                c_BOOT: begin
                    r_state <= c_FETCH;
                    if (flush) begin
                        r_pc         <= flush_pc;
                        r_fetch_addr <= flush_pc;
                    end else begin
                        r_fetch_addr <= r_pc;
                    end
                end
                c_FETCH: begin
                    if (flush) begin
                        r_pc <= flush_pc;
                        // Request completed this cycle: refetch at once.
                        // Otherwise the in-flight access must drain first.
                        if (imem_ack) begin
                            r_fetch_addr <= flush_pc;
                        end else begin
                            r_state <= c_DRAIN;
                        end
                    end else if (imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_state       <= c_VALID;
                    end
                end
                c_VALID: begin
                    if (flush) begin
                        r_pc          <= flush_pc;
                        r_fetch_addr  <= flush_pc;
                        r_instr_valid <= 1'b0;
                        r_state       <= c_FETCH;
                    end else if (instr_ready) begin
                        r_pc          <= nextpc;
                        r_fetch_addr  <= nextpc;
                        r_instret     <= r_instret + 32'd1;
                        r_instr_valid <= 1'b0;
                        r_state       <= c_FETCH;
                    end
                end
                default: begin
                    if (flush) begin
                        r_pc <= flush_pc;
                    end
                    if (imem_ack) begin
                        r_fetch_addr <= flush ? flush_pc : r_pc;
                        r_state      <= c_FETCH;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch
// Purpose  : Directed self-checking bench for pc_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] nextpc;
    logic [31:0] outputpc;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] flush_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instret;

    int errors = 0;
    int checks = 0;

    pc_fetch #(.RESET_PC(32'h0000_0010)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .nextpc      (nextpc),
        .outputpc    (outputpc),
        .pc          (pc),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instret     (instret)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        nextpc      = 32'd0;
        flush       = 1'b0;
        flush_pc    = 32'd0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b0;
        tick();
        tick();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_pc", pc, 32'h10);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_instr", instr, 32'd0);

        // Boot: cycle 1 after release is BOOT, cycle 2 requests.
        reset = 1'b0;
        tick();
        check("boot_req", {31'd0, imem_req}, 32'd1);
        check("boot_addr", imem_addr, 32'h10);
        imem_ack = 1'b1; imem_rdata = 32'hAAAA_0001;
        tick();
        imem_ack = 1'b0;
        check("first_valid", {31'd0, instr_valid}, 32'd1);
        check("first_instr", instr, 32'hAAAA_0001);
        check("first_pc", pc, 32'h10);
        check("first_outpc", outputpc, 32'h11);
        check("first_instret", instret, 32'd0);
        check("first_req", {31'd0, imem_req}, 32'd0);

        // Sequential run: five retires, zero-wait memory.
        for (int i = 0; i < 5; i++) begin
            instr_ready = 1'b1; nextpc = 32'h11 + i;
            tick();
            instr_ready = 1'b0;
            check("seq_valid0", {31'd0, instr_valid}, 32'd0);
            check("seq_req", {31'd0, imem_req}, 32'd1);
            check("seq_addr", imem_addr, 32'h11 + i);
            check("seq_instret", instret, i + 1);
            if (i < 4) begin
                imem_ack = 1'b1; imem_rdata = 32'hB000_0000 + i;
                tick();
                imem_ack = 1'b0;
                check("seq_valid1", {31'd0, instr_valid}, 32'd1);
                check("seq_instr", instr, 32'hB000_0000 + i);
            end
        end
        check("seq_pc", pc, 32'h15);

        // Branch taken.
        imem_ack = 1'b1; imem_rdata = 32'hC000_0001;
        tick();
        imem_ack = 1'b0;
        instr_ready = 1'b1; nextpc = 32'h40;
        tick();
        instr_ready = 1'b0;
        check("br_addr", imem_addr, 32'h40);
        check("br_pc", pc, 32'h40);
        check("br_instret", instret, 32'd6);

        // Three wait states.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ws_req", {31'd0, imem_req}, 32'd1);
            check("ws_addr", imem_addr, 32'h40);
            check("ws_valid", {31'd0, instr_valid}, 32'd0);
        end
        imem_ack = 1'b1; imem_rdata = 32'h0000_1234;
        tick();
        imem_ack = 1'b0;
        check("ws_valid_after", {31'd0, instr_valid}, 32'd1);
        check("ws_instr", instr, 32'h0000_1234);
        // Stray ack while VALID must be ignored.
        imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
        tick();
        imem_ack = 1'b0;
        check("stray_instr", instr, 32'h0000_1234);
        check("stray_valid", {31'd0, instr_valid}, 32'd1);
        instr_ready = 1'b1; nextpc = 32'h20;
        tick();
        instr_ready = 1'b0;
        check("ws_retire_instret", instret, 32'd7);

        // Flush during FETCH of 0x20 to 0x80.
        flush = 1'b1; flush_pc = 32'h80;
        tick();
        flush = 1'b0;
        check("dr_req", {31'd0, imem_req}, 32'd1);
        check("dr_addr", imem_addr, 32'h20);
        check("dr_pc", pc, 32'h80);
        tick();
        check("dr_addr_hold", imem_addr, 32'h20);
        imem_ack = 1'b1; imem_rdata = 32'h0000_DEAD;
        tick();
        imem_ack = 1'b0;
        check("dr_no_valid", {31'd0, instr_valid}, 32'd0);
        check("dr_new_addr", imem_addr, 32'h80);
        check("dr_instret", instret, 32'd7);
        imem_ack = 1'b1; imem_rdata = 32'h0000_5555;
        tick();
        imem_ack = 1'b0;
        check("dr_instr", instr, 32'h0000_5555);

        // Flush and ready together in VALID.
        flush = 1'b1; flush_pc = 32'h90; instr_ready = 1'b1; nextpc = 32'h81;
        tick();
        flush = 1'b0; instr_ready = 1'b0;
        check("fr_instret", instret, 32'd7);
        check("fr_pc", pc, 32'h90);
        check("fr_valid", {31'd0, instr_valid}, 32'd0);
        check("fr_addr", imem_addr, 32'h90);

        // Flush with ack in FETCH to the top address: outputpc wraps.
        flush = 1'b1; flush_pc = 32'hFFFF_FFFF; imem_ack = 1'b1; imem_rdata = 32'h0000_0BAD;
        tick();
        flush = 1'b0; imem_ack = 1'b0;
        check("wrap_pc", pc, 32'hFFFF_FFFF);
        check("wrap_outpc", outputpc, 32'h0);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFF);
        check("wrap_valid", {31'd0, instr_valid}, 32'd0);

        // Enter DRAIN, then reset with a late ack.
        flush = 1'b1; flush_pc = 32'h30;
        tick();
        flush = 1'b0;
        check("rd_req", {31'd0, imem_req}, 32'd1);
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0000_0BAD;
        tick();
        reset = 1'b0;
        check("rd_boot_req", {31'd0, imem_req}, 32'd0);
        check("rd_pc", pc, 32'h10);
        check("rd_instret", instret, 32'd0);
        tick();
        imem_ack = 1'b0;
        check("rd_fetch_req", {31'd0, imem_req}, 32'd1);
        check("rd_fetch_addr", imem_addr, 32'h10);
        check("rd_fetch_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check("rd_still_req", {31'd0, imem_req}, 32'd1);
        check("rd_still_novalid", {31'd0, instr_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
